// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the 32 x 32-bit RISC-V register bank.
// Strobe encodings live here so the top and the read ports agree on polarity.
package regbank_pkg;

    localparam int REGBANK_DATA_W = 32;
    localparam int REGBANK_ADDR_W = 5;
    localparam int REGBANK_DEPTH  = 32;

    localparam logic CS_ACTIVE = 1'b0;
    localparam logic RD        = 1'b1;
    localparam logic WR        = 1'b0;

    // True when an address maps onto the hardwired-zero register x0.
    function automatic logic x0_locked(input int unsigned addr, input int hardwire);
        return (hardwire != 0) && (addr == 0);
    endfunction

endpackage

// File: rtl/reg_bank_rd_port.sv
// One registered read port: DEPTH:1 mux feeding an output register that only
// refreshes on an enabled read cycle and otherwise holds its last value.
module reg_bank_rd_port
    import regbank_pkg::*;
#(
    parameter int DATA_W      = REGBANK_DATA_W,
    parameter int ADDR_W      = REGBANK_ADDR_W,
    parameter int DEPTH       = REGBANK_DEPTH,
    parameter int HARDWIRE_X0 = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_sel,
    input  logic [DATA_W-1:0] i_mem [DEPTH],
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_mux_data;
    logic [DATA_W-1:0] r_data_reg;

    // x0 is forced to zero here as well, so the read path never depends on
    // the storage array having discarded every x0 write.
    always_comb begin
        w_mux_data = i_mem[i_sel];
        if (x0_locked(32'(i_sel), HARDWIRE_X0)) begin
            w_mux_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_reg <= '0;
        end else if (i_rd_en) begin
            r_data_reg <= w_mux_data;
        end
    end

    assign o_data = r_data_reg;

endmodule

// File: rtl/reg_bank32.sv
// 32 x 32-bit general-purpose register file: one write port, two registered
// read ports, gated by active-low chip select and a read/write-bar strobe.
module reg_bank32
    import regbank_pkg::*;
#(
    parameter int DATA_W      = REGBANK_DATA_W,
    parameter int ADDR_W      = REGBANK_ADDR_W,
    parameter int DEPTH       = REGBANK_DEPTH,
    parameter int HARDWIRE_X0 = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] regSrc0,
    output logic [DATA_W-1:0] regSrc1,
    input  logic [DATA_W-1:0] regDst,
    input  logic [ADDR_W-1:0] regSelSrc0,
    input  logic [ADDR_W-1:0] regSelSrc1,
    input  logic [ADDR_W-1:0] regSelDst,
    input  logic              RDWRBar,
    input  logic              CSBar
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_rd_en;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_rd_sel  [2];
    logic [DATA_W-1:0] w_rd_data [2];

    assign w_rd_en = (CSBar == CS_ACTIVE) && (RDWRBar == RD);
    assign w_wr_en = (CSBar == CS_ACTIVE) && (RDWRBar == WR)
                     && !x0_locked(32'(regSelDst), HARDWIRE_X0);

    // Reset wins over any strobe combination on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[regSelDst] <= regDst;
        end
    end

    assign w_rd_sel[0] = regSelSrc0;
    assign w_rd_sel[1] = regSelSrc1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            reg_bank_rd_port #(
                .DATA_W      (DATA_W),
                .ADDR_W      (ADDR_W),
                .DEPTH       (DEPTH),
                .HARDWIRE_X0 (HARDWIRE_X0)
            ) u_rd_port (
                .clk     (clk),
                .reset   (reset),
                .i_rd_en (w_rd_en),
                .i_sel   (w_rd_sel[gi]),
                .i_mem   (r_mem),
                .o_data  (w_rd_data[gi])
            );
        end
    endgenerate

    assign regSrc0 = w_rd_data[0];
    assign regSrc1 = w_rd_data[1];

endmodule

// File: tb/tb_reg_bank32.sv
// Directed bench for reg_bank32: one x0-hardwired instance and one with x0 as
// an ordinary register, both driven by the same strobes.
module tb_reg_bank32;

    logic        clk;
    logic        reset;
    logic [31:0] regDst;
    logic [4:0]  regSelSrc0;
    logic [4:0]  regSelSrc1;
    logic [4:0]  regSelDst;
    logic        RDWRBar;
    logic        CSBar;
    logic [31:0] src0_hw, src1_hw;
    logic [31:0] src0_nx, src1_nx;

    int checks = 0;
    int errors = 0;

    reg_bank32 #(.HARDWIRE_X0(1)) dut_hw (
        .clk        (clk),
        .reset      (reset),
        .regSrc0    (src0_hw),
        .regSrc1    (src1_hw),
        .regDst     (regDst),
        .regSelSrc0 (regSelSrc0),
        .regSelSrc1 (regSelSrc1),
        .regSelDst  (regSelDst),
        .RDWRBar    (RDWRBar),
        .CSBar      (CSBar)
    );

    reg_bank32 #(.HARDWIRE_X0(0)) dut_nx (
        .clk        (clk),
        .reset      (reset),
        .regSrc0    (src0_nx),
        .regSrc1    (src1_nx),
        .regDst     (regDst),
        .regSelSrc0 (regSelSrc0),
        .regSelSrc1 (regSelSrc1),
        .regSelDst  (regSelDst),
        .RDWRBar    (RDWRBar),
        .CSBar      (CSBar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Each operation occupies exactly one rising edge, then the bank goes idle.
    task automatic op_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        regSelDst = addr;
        regDst    = data;
        RDWRBar   = 1'b0;
        CSBar     = 1'b0;
        @(posedge clk);
        #1;
        CSBar = 1'b1;
        $display("WR   addr=%0d data=%08h", addr, data);
    endtask

    task automatic op_read(input logic [4:0] a0, input logic [4:0] a1);
        @(negedge clk);
        regSelSrc0 = a0;
        regSelSrc1 = a1;
        RDWRBar    = 1'b1;
        CSBar      = 1'b0;
        @(posedge clk);
        #1;
        CSBar = 1'b1;
        $display("RD   a0=%0d a1=%0d -> hw %08h %08h  nx %08h %08h",
                 a0, a1, src0_hw, src1_hw, src0_nx, src1_nx);
    endtask

    task automatic op_idle(input logic [4:0] a0, input logic [4:0] a1);
        @(negedge clk);
        regSelSrc0 = a0;
        regSelSrc1 = a1;
        RDWRBar    = 1'b1;
        CSBar      = 1'b1;
        @(posedge clk);
        #1;
        $display("IDLE a0=%0d a1=%0d -> hw %08h %08h", a0, a1, src0_hw, src1_hw);
    endtask

    task automatic op_reset(input logic cs, input logic rdwr);
        @(negedge clk);
        reset   = 1'b1;
        CSBar   = cs;
        RDWRBar = rdwr;
        @(posedge clk);
        #1;
        reset = 1'b0;
        CSBar = 1'b1;
        $display("RST  cs=%0b rdwr=%0b", cs, rdwr);
    endtask

    initial begin
        logic [31:0] exp_hw;
        reset      = 1'b1;
        CSBar      = 1'b1;
        RDWRBar    = 1'b1;
        regDst     = '0;
        regSelSrc0 = '0;
        regSelSrc1 = '0;
        regSelDst  = '0;

        // 1. Reset, then read address 5 on both ports.
        op_reset(1'b1, 1'b1);
        chk("rst_out_src0", src0_hw, 32'h0);
        chk("rst_out_src1", src1_hw, 32'h0);
        op_read(5'd5, 5'd5);
        chk("rst_rd5_src0", src0_hw, 32'h0);
        chk("rst_rd5_src1", src1_hw, 32'h0);
        chk("rst_rd5_nx",   src0_nx, 32'h0);

        // 2. Write, idle edge, then read back with 1-cycle latency.
        op_write(5'd3, 32'hFAEAFAEA);
        chk("wr_holds_src0", src0_hw, 32'h0);
        op_idle(5'd3, 5'd3);
        chk("idle_no_refresh", src0_hw, 32'h0);
        op_read(5'd3, 5'd5);
        chk("rd3_src0", src0_hw, 32'hFAEAFAEA);
        chk("rd5_src1", src1_hw, 32'h0);

        // 3. Fill every register with i*10, read back on both ports.
        for (int i = 0; i < 32; i++) begin
            op_write(5'(i), 32'(i * 10));
        end
        for (int i = 0; i < 32; i++) begin
            exp_hw = (i == 0) ? 32'h0 : 32'(i * 10);
            op_read(5'(i), 5'(i));
            chk($sformatf("fill_hw_src0_%0d", i), src0_hw, exp_hw);
            chk($sformatf("fill_hw_src1_%0d", i), src1_hw, exp_hw);
            chk($sformatf("fill_nx_src0_%0d", i), src0_nx, 32'(i * 10));
        end
        op_read(5'd31, 5'd1);
        chk("split_src0_31", src0_hw, 32'd310);
        chk("split_src1_1",  src1_hw, 32'd10);

        // 4. Write to x0: discarded when hardwired, kept otherwise.
        op_write(5'd0, 32'h12345678);
        op_read(5'd0, 5'd0);
        chk("x0_hw_src0", src0_hw, 32'h0);
        chk("x0_hw_src1", src1_hw, 32'h0);
        chk("x0_nx_src0", src0_nx, 32'h12345678);
        chk("x0_nx_src1", src1_nx, 32'h12345678);

        // 5. Hold: outputs keep the last read while the bank is idle.
        op_read(5'd7, 5'd7);
        chk("hold_pre_src0", src0_hw, 32'd70);
        op_idle(5'd1, 5'd2);
        op_idle(5'd9, 5'd12);
        chk("hold_src0", src0_hw, 32'd70);
        chk("hold_src1", src1_hw, 32'd70);
        op_read(5'd1, 5'd2);
        chk("after_hold_src0", src0_hw, 32'd10);
        chk("after_hold_src1", src1_hw, 32'd20);

        // 6. Mid-run reset with a write strobe active: reset wins and clears all.
        regSelDst = 5'd9;
        regDst    = 32'hDEADBEEF;
        op_reset(1'b0, 1'b0);
        chk("mrst_out_src0", src0_hw, 32'h0);
        op_read(5'd31, 5'd9);
        chk("mrst_rd31", src0_hw, 32'h0);
        chk("mrst_rd9",  src1_hw, 32'h0);
        op_read(5'd0, 5'd3);
        chk("mrst_nx_x0", src0_nx, 32'h0);
        chk("mrst_nx_3",  src1_nx, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
